fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the pipelined LEGv8 core that succeeds the single-cycle datapath. It owns the program counter and drives the instruction-memory address. It latches the returned instruction plus its PC into the IF/ID register, which the decode stage consumes. It handles the decode-stage stall, the taken-branch redirect/flush from downstream, and misaligned-target faults.

Parameters:
ADDR_W, 64, width of PC and branch target
RESET_PC, 64'h0, PC value loaded on reset
CNT_W, 32, width of fetched-instruction counter

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
imem_addr  output  ADDR_W  instruction-memory address, equal to current PC (combinational from PC register)
imem_instr  input  32  instruction word returned combinationally for imem_addr
stall  input  1  decode hazard: hold PC and IF/ID contents
redirect  input  1  taken branch (CBZ/B.LT/B) resolved downstream
redirect_pc  input  ADDR_W  branch target address
ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble)
ifid_instr  output  32  latched instruction word
ifid_pc  output  ADDR_W  PC of latched instruction
fault  output  1  sticky misaligned-target fault
fetch_count  output  CNT_W  number of instructions delivered valid into IF/ID

Behaviour:
- Reset (rst=1 at posedge): pc<=RESET_PC; ifid_valid<=0; ifid_instr<=NOP; ifid_pc<=0; fault<=0; fetch_count<=0. Reset overrides all other inputs, including mid-stall and mid-redirect.
- Priority, highest first: rst > fault-hold > redirect > stall > normal advance.
- Normal (no stall/redirect/fault):
  - ifid_instr<=imem_instr; ifid_pc<=pc; ifid_valid<=1; pc<=pc+4.
  - Latency: instruction at address A appears in IF/ID one cycle after PC==A.
- Stall=1: pc, ifid_* and fetch_count hold. No memory side effects; imem_addr stays constant.
- Redirect=1 with redirect_pc[1:0]==0:
  - pc<=redirect_pc.
  - ifid_valid<=0 and ifid_instr<=NOP (flush of the wrong-path instruction).
  - Redirect wins over a simultaneous stall: the flush is applied and the stall is ignored that cycle.
- Redirect=1 with redirect_pc[1:0]!=0:
  - fault<=1; pc is not updated; IF/ID flushed to a bubble.
- Fault=1 (sticky until rst):
  - pc frozen; ifid_valid<=0 every cycle; redirects and stalls ignored.
- PC arithmetic: modulo 2^ADDR_W; pc+4 at the top address wraps to 0 with no flag.
- fetch_count:
  - Increments by 1 on each cycle where ifid_valid is loaded with 1.
  - Saturates at all-ones; never wraps.
- First instruction: the cycle rst is sampled 0, IF/ID captures the word at RESET_PC with ifid_valid=1.
- NOP constant: 32'hD503201F (LEGv8 NOP encoding). Downstream treats ifid_valid=0 as a bubble regardless of ifid_instr.
- No combinational path from stall/redirect to imem_addr. All outputs are registered except imem_addr, which is the PC register.

Decomposition:
- Shared package cpu_pkg holds:
  - INSTR_W=32, ADDR_W default, LEGV8_NOP constant.
  - Typedef ifid_t struct {logic valid; logic [31:0] instr; logic [ADDR_W-1:0] pc;}, reused by decode for the ID/EX boundary pattern.
- One natural sub-module, ifid_reg: the IF/ID register with hold (stall) and flush (bubble insert) controls, reused for later pipeline registers.
- PC, next-PC select and fault logic stay in fetch_stage.

Test Plan:
- Reset then free-run 4 cycles, imem word = address-tagged (instr = 32'hA000_0000 | addr) -> ifid_pc = 0,4,8,12 on successive cycles with ifid_valid=1; fetch_count=4.
- Stall held 3 cycles while pc=8 -> imem_addr stays 8, ifid_pc stays 4, fetch_count unchanged. Release -> ifid_pc=8 next cycle.
- Redirect to 0x100 while pc=12 -> next cycle ifid_valid=0 and ifid_instr=NOP, pc=0x100. The following cycle ifid_pc=0x100, valid=1.
- Redirect to 0x40 and stall asserted in the same cycle -> flush applied, pc=0x40 next cycle (redirect wins).
- Redirect to 0x102 -> fault=1, pc holds, ifid_valid=0 for 5 further cycles despite a redirect to 0x200. Assert rst -> fault=0, pc=0.
- Assert rst mid-run at pc=0x20 during a stall -> next cycle pc=0, ifid_valid=0, fetch_count=0. Start RESET_PC=0xFFFF_FFFF_FFFF_FFFC -> after 2 advances ifid_pc=0 (wrap).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined LEGv8 core.
// Contents: instruction/address widths, LEGv8 NOP encoding, and the IF/ID payload struct.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;

  // LEGv8 NOP; a bubble carries this so stray decodes are harmless
  localparam logic [INSTR_W-1:0] LEGV8_NOP = 32'hD503_201F;

  // Pipeline-register payload; the ID/EX boundary follows the same shape
  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register with hold and flush (bubble insert) controls.
// Ports: clk, rst (sync, active-high); load_c/flush_c controls; d_instr/d_pc data in;
//        q_valid/q_instr/q_pc registered outputs.
// Priority: rst > flush > load > hold (neither asserted).
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_c,
  input  logic                flush_c,
  input  logic [INSTR_W-1:0]  d_instr,
  input  logic [ADDR_W-1:0]   d_pc,
  output logic                q_valid,
  output logic [INSTR_W-1:0]  q_instr,
  output logic [ADDR_W-1:0]   q_pc
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q,    pc_d;

  // Next-state select; flush keeps the old pc since a bubble's pc is don't-care
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_c) begin
      valid_d = 1'b0;
      instr_d = LEGV8_NOP;
    end else if (load_c) begin
      valid_d = 1'b1;
      instr_d = d_instr;
      pc_d    = d_pc;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= LEGV8_NOP;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign q_valid = valid_q;
  assign q_instr = instr_q;
  assign q_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, fills the IF/ID register.
// Ports: clk, rst (sync, active-high); imem_addr (= PC register) / imem_instr;
//        stall, redirect, redirect_pc from downstream; ifid_valid/ifid_instr/ifid_pc;
//        fault (sticky misaligned redirect); fetch_count (saturating valid-fetch count).
// Priority: rst > fault-hold > redirect > stall > advance.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned            ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0,
  parameter int unsigned            CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_instr,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                ifid_valid,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic [ADDR_W-1:0]   ifid_pc,
  output logic                fault,
  output logic [CNT_W-1:0]    fetch_count
);

  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              ifid_load_c;
  logic              ifid_flush_c;

  // Next-PC select, fault capture and fetch counter
  always_comb begin
    pc_d         = pc_q;
    fault_d      = fault_q;
    cnt_d        = cnt_q;
    ifid_load_c  = 1'b0;
    ifid_flush_c = 1'b0;
    if (fault_q) begin
      ifid_flush_c = 1'b1;
    end else if (redirect) begin
      // Wrong-path word is dropped whether or not the target is usable
      ifid_flush_c = 1'b1;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d = redirect_pc;
      end else begin
        fault_d = 1'b1;
      end
    end else if (!stall) begin
      pc_d        = pc_q + ADDR_W'(4);
      ifid_load_c = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  ifid_reg #(
    .ADDR_W (ADDR_W)
  ) u_ifid_reg (
    .clk     (clk),
    .rst     (rst),
    .load_c  (ifid_load_c),
    .flush_c (ifid_flush_c),
    .d_instr (imem_instr),
    .d_pc    (pc_q),
    .q_valid (ifid_valid),
    .q_instr (ifid_instr),
    .q_pc    (ifid_pc)
  );

  assign imem_addr   = pc_q;
  assign fault       = fault_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: main instance at RESET_PC=0, plus a second
// instance starting at the top address with a 2-bit counter for wrap/saturation.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503_201F;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic        fault;
  logic [31:0] fetch_count;

  logic        rst_w;
  logic [63:0] imem_addr_w;
  logic [31:0] imem_instr_w;
  logic        stall_w    = 1'b0;
  logic        redirect_w = 1'b0;
  logic [63:0] redirect_pc_w = 64'h0;
  logic        ifid_valid_w;
  logic [31:0] ifid_instr_w;
  logic [63:0] ifid_pc_w;
  logic        fault_w;
  logic [1:0]  fetch_count_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Address-tagged instruction memory
  assign imem_instr   = 32'hA000_0000 | imem_addr[31:0];
  assign imem_instr_w = 32'hA000_0000 | imem_addr_w[31:0];

  fetch_stage #(.ADDR_W(64), .RESET_PC(64'h0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .fault(fault), .fetch_count(fetch_count)
  );

  fetch_stage #(.ADDR_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst_w), .imem_addr(imem_addr_w), .imem_instr(imem_instr_w),
    .stall(stall_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
    .ifid_valid(ifid_valid_w), .ifid_instr(ifid_instr_w), .ifid_pc(ifid_pc_w),
    .fault(fault_w), .fetch_count(fetch_count_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
    step(); step();

    // Reset state
    chk("rst_addr",  imem_addr, 64'h0);
    chk("rst_valid", 64'(ifid_valid), 64'h0);
    chk("rst_instr", 64'(ifid_instr), 64'(NOP));
    chk("rst_pc",    ifid_pc, 64'h0);
    chk("rst_fault", 64'(fault), 64'h0);
    chk("rst_cnt",   64'(fetch_count), 64'h0);
    chk("w_rst_addr", imem_addr_w, 64'hFFFF_FFFF_FFFF_FFFC);

    // Free run: first word at RESET_PC appears with valid
    rst = 1'b0; rst_w = 1'b0;
    step();
    chk("adv0_valid", 64'(ifid_valid), 64'h1);
    chk("adv0_pc",    ifid_pc, 64'h0);
    chk("adv0_instr", 64'(ifid_instr), 64'hA000_0000);
    chk("adv0_addr",  imem_addr, 64'h4);
    chk("w_adv0_pc",  ifid_pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w_adv0_addr", imem_addr_w, 64'h0);
    step();
    chk("adv1_pc",    ifid_pc, 64'h4);
    chk("adv1_instr", 64'(ifid_instr), 64'hA000_0004);
    chk("w_wrap_pc",  ifid_pc_w, 64'h0);
    chk("w_cnt2",     64'(fetch_count_w), 64'h2);

    // Stall for 3 cycles at pc=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", imem_addr, 64'h8);
      chk("stall_pc",   ifid_pc, 64'h4);
      chk("stall_cnt",  64'(fetch_count), 64'h2);
    end
    chk("w_cnt_sat", 64'(fetch_count_w), 64'h3);
    stall = 1'b0;
    step();
    chk("rel_pc",    ifid_pc, 64'h8);
    chk("rel_valid", 64'(ifid_valid), 64'h1);
    step();
    chk("adv3_pc",   ifid_pc, 64'hC);
    chk("adv3_cnt",  64'(fetch_count), 64'h4);
    chk("adv3_addr", imem_addr, 64'h10);

    // Redirect to 0x100
    redirect = 1'b1; redirect_pc = 64'h100;
    step();
    chk("redir_valid", 64'(ifid_valid), 64'h0);
    chk("redir_instr", 64'(ifid_instr), 64'(NOP));
    chk("redir_addr",  imem_addr, 64'h100);
    chk("redir_cnt",   64'(fetch_count), 64'h4);
    redirect = 1'b0;
    step();
    chk("tgt_pc",    ifid_pc, 64'h100);
    chk("tgt_valid", 64'(ifid_valid), 64'h1);
    chk("tgt_instr", 64'(ifid_instr), 64'hA000_0100);
    chk("tgt_cnt",   64'(fetch_count), 64'h5);

    // Redirect wins over simultaneous stall
    redirect = 1'b1; redirect_pc = 64'h40; stall = 1'b1;
    step();
    chk("rs_valid", 64'(ifid_valid), 64'h0);
    chk("rs_addr",  imem_addr, 64'h40);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk("rs_pc",  ifid_pc, 64'h40);
    chk("rs_cnt", 64'(fetch_count), 64'h6);

    // Misaligned redirect -> sticky fault, pc frozen at 0x44
    redirect = 1'b1; redirect_pc = 64'h102;
    step();
    chk("flt_set",   64'(fault), 64'h1);
    chk("flt_addr",  imem_addr, 64'h44);
    chk("flt_valid", 64'(ifid_valid), 64'h0);
    redirect_pc = 64'h200;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("flt_hold",  64'(fault), 64'h1);
      chk("flt_haddr", imem_addr, 64'h44);
      chk("flt_hval",  64'(ifid_valid), 64'h0);
      chk("flt_hcnt",  64'(fetch_count), 64'h6);
    end
    redirect = 1'b0;
    rst = 1'b1;
    step();
    chk("flt_clr",   64'(fault), 64'h0);
    chk("flt_raddr", imem_addr, 64'h0);
    chk("flt_rcnt",  64'(fetch_count), 64'h0);
    rst = 1'b0;

    // Run to pc=0x20, stall, then reset during stall+redirect
    for (int i = 0; i < 8; i++) step();
    chk("run_addr", imem_addr, 64'h20);
    chk("run_pc",   ifid_pc, 64'h1C);
    chk("run_cnt",  64'(fetch_count), 64'h8);
    stall = 1'b1;
    step();
    chk("run_stall", imem_addr, 64'h20);
    redirect = 1'b1; redirect_pc = 64'h80; rst = 1'b1;
    step();
    chk("mid_addr",  imem_addr, 64'h0);
    chk("mid_valid", 64'(ifid_valid), 64'h0);
    chk("mid_cnt",   64'(fetch_count), 64'h0);
    chk("mid_instr", 64'(ifid_instr), 64'(NOP));
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    step();
    chk("post_pc",    ifid_pc, 64'h0);
    chk("post_valid", 64'(ifid_valid), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
